// File: rtl/spi_slave_if.sv
// SPI pin bundle plus the local TX/RX word interface of the SPI target.
interface spi_slave_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              ss;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic              cpol;
    logic              cpha;
    logic [DATA_W-1:0] tx_data;
    logic              tx_we;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              tx_empty;
    logic              frame_err;

    modport slave (
        input  sclk, ss, mosi, cpol, cpha, tx_data, tx_we,
        output miso, miso_oe, rx_data, rx_valid, busy, tx_empty, frame_err
    );

    modport master (
        output sclk, ss, mosi, cpol, cpha, tx_data, tx_we,
        input  miso, miso_oe, rx_data, rx_valid, busy, tx_empty, frame_err
    );
endinterface

// File: rtl/spi_slave.sv
// SPI target: pins synchronised into clk, MSB-first words in all CPOL/CPHA modes; pin-to-action SYNC_STAGES+1 clk.
// No backpressure: rx_valid is a bare pulse and a TX underrun simply resends the held word.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_prev, ss_prev;
    logic                   cpol_q, cpha_q;
    logic [DATA_W-1:0]      hold, tx_shift, rx_shift;
    logic [CNT_W-1:0]       bit_cnt;

    logic              sclk_s, ss_s, mosi_s;
    logic              sclk_rise, sclk_fall, lead, trail;
    logic              sample_edge, shift_edge, ss_fall, ss_rise, word_done;
    logic [DATA_W-1:0] reload_val, rx_next;
    logic [CNT_W-1:0]  cnt_inc;

    always_comb begin
        sclk_s      = sclk_sync[SYNC_STAGES-1];
        ss_s        = ss_sync[SYNC_STAGES-1];
        mosi_s      = mosi_sync[SYNC_STAGES-1];
        sclk_rise   = sclk_s & ~sclk_prev;
        sclk_fall   = ~sclk_s & sclk_prev;
        ss_fall     = ~ss_s & ss_prev;
        ss_rise     = ss_s & ~ss_prev;
        lead        = cpol_q ? sclk_fall : sclk_rise;
        trail       = cpol_q ? sclk_rise : sclk_fall;
        sample_edge = cpha_q ? trail : lead;
        shift_edge  = cpha_q ? lead : trail;
        // A write landing on a reload cycle bypasses the holding register.
        reload_val  = bus.tx_we ? bus.tx_data : hold;
        rx_next     = {rx_shift[DATA_W-2:0], mosi_s};
        cnt_inc     = bit_cnt + CNT_W'(1);
        word_done   = sample_edge && (cnt_inc == CNT_W'(DATA_W));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            sclk_sync     <= '0;
            ss_sync       <= '0;
            mosi_sync     <= '0;
            sclk_prev     <= 1'b0;
            ss_prev       <= 1'b0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            hold          <= '0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            bus.miso      <= 1'b0;
            bus.miso_oe   <= 1'b0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.tx_empty  <= 1'b1;
            bus.frame_err <= 1'b0;
        end else begin
            sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            ss_sync       <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
            mosi_sync     <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev     <= sclk_s;
            ss_prev       <= ss_s;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;

            if (bus.tx_we) begin
                hold         <= bus.tx_data;
                bus.tx_empty <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bus.busy    <= 1'b0;
                    bus.miso_oe <= 1'b0;
                    bus.miso    <= 1'b0;
                    if (ss_fall) begin
                        state        <= ACTIVE;
                        bus.busy     <= 1'b1;
                        bus.miso_oe  <= 1'b1;
                        cpol_q       <= bus.cpol;
                        cpha_q       <= bus.cpha;
                        bit_cnt      <= '0;
                        rx_shift     <= '0;
                        bus.tx_empty <= ~bus.tx_we;
                        // CPHA=0 must have the MSB on the wire before the first leading edge.
                        if (!bus.cpha) begin
                            bus.miso <= reload_val[DATA_W-1];
                            tx_shift <= {reload_val[DATA_W-2:0], 1'b0};
                        end else begin
                            bus.miso <= 1'b0;
                            tx_shift <= reload_val;
                        end
                    end
                end
                ACTIVE: begin
                    if (sample_edge) begin
                        rx_shift <= rx_next;
                        if (word_done) begin
                            bus.rx_data  <= rx_next;
                            bus.rx_valid <= 1'b1;
                            bit_cnt      <= '0;
                            tx_shift     <= reload_val;
                            bus.tx_empty <= ~bus.tx_we;
                        end else begin
                            bit_cnt <= cnt_inc;
                        end
                    end
                    if (shift_edge) begin
                        bus.miso <= tx_shift[DATA_W-1];
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    end
                    // A sample in the same cycle as deselect is counted before judging the abort.
                    if (ss_rise) begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.miso_oe   <= 1'b0;
                        bus.miso      <= 1'b0;
                        bus.frame_err <= ~word_done & (sample_edge | (bit_cnt != '0));
                        bit_cnt       <= '0;
                        rx_shift      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Bench: behavioural SPI master driving the target, with a holding-register model predicting miso words.
module tb_spi_slave;
    localparam int DATA_W = 8;
    localparam int H      = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(DATA_W)) bus ();
    spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;
    int ferr_cnt = 0;
    logic [DATA_W-1:0] rx_q[$];

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) rx_q.push_back(bus.rx_data);
        if (bus.frame_err === 1'b1) ferr_cnt++;
    end

    bit m_cpol, m_cpha, scramble;
    logic [DATA_W-1:0] f_mo[4], f_mi[4], f_exp[4], f_mid_dat[4], f_end_dat[4];
    bit f_mid[4], f_end[4];
    logic [DATA_W-1:0] model_hold = '0;
    logic [DATA_W-1:0] last_rx = '0;
    logic busy_f2, busy_f3, busy_r2, busy_r3, miso_start, empty_after_we;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [DATA_W-1:0] d);
        bus.tx_data = d;
        bus.tx_we   = 1'b1;
        wait_clk(1);
        bus.tx_we   = 1'b0;
        model_hold  = d;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 4; i++) begin
            f_mid[i] = 1'b0;
            f_end[i] = 1'b0;
        end
    endtask

    // Word w carries whatever the holding register held at its reload; writes during w feed w+1.
    task automatic model_frame(input int nw);
        for (int w = 0; w < nw; w++) begin
            f_exp[w] = model_hold;
            if (f_mid[w]) model_hold = f_mid_dat[w];
            if (f_end[w]) model_hold = f_end_dat[w];
        end
    endtask

    task automatic after_sample(input bit do_we, input logic [DATA_W-1:0] d);
        if (do_we) begin
            wait_clk(2);
            bus.tx_data = d;
            bus.tx_we   = 1'b1;
            wait_clk(1);
            bus.tx_we   = 1'b0;
            empty_after_we = bus.tx_empty;
            wait_clk(H - 3);
        end else begin
            wait_clk(H);
        end
    endtask

    task automatic xfer_word(input int w, input int nbits);
        logic [DATA_W-1:0] mi;
        mi = '0;
        for (int b = 0; b < nbits; b++) begin
            if (b == 4 && f_mid[w]) begin
                bus.tx_data = f_mid_dat[w];
                bus.tx_we   = 1'b1;
                wait_clk(1);
                bus.tx_we   = 1'b0;
            end
            if (!m_cpha) begin
                bus.mosi = f_mo[w][DATA_W-1-b];
                wait_clk(H);
                mi = {mi[DATA_W-2:0], bus.miso};
                bus.sclk = ~m_cpol;
                after_sample(b == DATA_W-1 && f_end[w], f_end_dat[w]);
                bus.sclk = m_cpol;
            end else begin
                bus.sclk = ~m_cpol;
                bus.mosi = f_mo[w][DATA_W-1-b];
                wait_clk(H);
                mi = {mi[DATA_W-2:0], bus.miso};
                bus.sclk = m_cpol;
                after_sample(b == DATA_W-1 && f_end[w], f_end_dat[w]);
            end
        end
        f_mi[w] = mi;
    endtask

    task automatic run_frame(input int nw, input int last_bits);
        bus.cpol = m_cpol;
        bus.cpha = m_cpha;
        bus.sclk = m_cpol;
        bus.mosi = 1'b0;
        wait_clk(H);
        bus.ss = 1'b0;
        @(posedge clk); @(posedge clk); #1 busy_f2 = bus.busy;
        @(posedge clk); #1 busy_f3 = bus.busy; miso_start = bus.miso;
        wait_clk(H);
        if (scramble) begin
            bus.cpol = 1'($urandom);
            bus.cpha = 1'($urandom);
        end
        for (int w = 0; w < nw; w++) xfer_word(w, (w == nw - 1) ? last_bits : DATA_W);
        wait_clk(H);
        bus.ss = 1'b1;
        @(posedge clk); @(posedge clk); #1 busy_r2 = bus.busy;
        @(posedge clk); #1 busy_r3 = bus.busy;
        wait_clk(H);
        bus.cpol = m_cpol;
        bus.cpha = m_cpha;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        wait_clk(3);
        obs = {bus.busy, bus.miso, bus.miso_oe, bus.rx_valid, bus.frame_err, bus.tx_empty, bus.rx_data};
        tests++;
        if (obs !== 14'b00000_1_00000000) begin
            fails++; $display("FAIL reset_outputs: got %b want %b", obs, 14'b00000_1_00000000);
        end
        rst = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_mode0();
        int e0;
        m_cpol = 0; m_cpha = 0; scramble = 0; clear_plan();
        host_write(8'h3C);
        tests++;
        if (bus.tx_empty !== 1'b0) begin fails++; $display("FAIL m0_tx_empty_after_we: got %b want 0", bus.tx_empty); end
        f_mo[0] = 8'hA5; model_frame(1);
        rx_q.delete(); e0 = ferr_cnt;
        run_frame(1, DATA_W);
        tests++;
        if (rx_q.size() != 1) begin fails++; $display("FAIL m0_rx_count: got %0d want 1", rx_q.size()); end
        tests++;
        if (bus.rx_data !== 8'hA5) begin fails++; $display("FAIL m0_rx_data: got %h want a5", bus.rx_data); end
        tests++;
        if (f_mi[0] !== f_exp[0]) begin fails++; $display("FAIL m0_master_rx: got %h want %h", f_mi[0], f_exp[0]); end
        tests++;
        if ({busy_f2, busy_f3, busy_r2, busy_r3} !== 4'b0110) begin
            fails++; $display("FAIL m0_busy_timing: got %b want 0110", {busy_f2, busy_f3, busy_r2, busy_r3});
        end
        tests++;
        if ({bus.tx_empty, bus.miso_oe, bus.miso} !== 3'b100) begin
            fails++; $display("FAIL m0_idle_after: got %b want 100", {bus.tx_empty, bus.miso_oe, bus.miso});
        end
        tests++;
        if (ferr_cnt != e0) begin fails++; $display("FAIL m0_no_frame_err: got %0d want %0d", ferr_cnt, e0); end
        last_rx = 8'hA5;
    endtask

    task automatic test_mode3();
        m_cpol = 1; m_cpha = 1; clear_plan();
        host_write(8'h81);
        f_mo[0] = 8'h7E; model_frame(1);
        rx_q.delete();
        run_frame(1, DATA_W);
        tests++;
        if (miso_start !== 1'b0) begin fails++; $display("FAIL m3_miso_before_edge: got %b want 0", miso_start); end
        tests++;
        if (rx_q.size() != 1 || bus.rx_data !== 8'h7E) begin
            fails++; $display("FAIL m3_rx: got %0d words, rx_data %h want 1 word 7e", rx_q.size(), bus.rx_data);
        end
        tests++;
        if (f_mi[0] !== 8'h81) begin fails++; $display("FAIL m3_master_rx: got %h want 81", f_mi[0]); end
        last_rx = 8'h7E;
    endtask

    task automatic test_two_word();
        logic [DATA_W-1:0] got;
        for (int pass = 0; pass < 2; pass++) begin
            m_cpol = 1; m_cpha = 0; clear_plan();
            host_write(8'hC3);
            f_mo[0] = 8'h12; f_mo[1] = 8'h34;
            f_mid[0] = (pass == 0); f_mid_dat[0] = 8'h5A;
            model_frame(2);
            rx_q.delete();
            run_frame(2, DATA_W);
            for (int w = 0; w < 2; w++) begin
                got = (w < rx_q.size()) ? rx_q[w] : 'x;
                tests++;
                if (got !== f_mo[w]) begin fails++; $display("FAIL two_rx[%0d] pass %0d: got %h want %h", w, pass, got, f_mo[w]); end
                tests++;
                if (f_mi[w] !== f_exp[w]) begin fails++; $display("FAIL two_master[%0d] pass %0d: got %h want %h", w, pass, f_mi[w], f_exp[w]); end
            end
            tests++;
            if (rx_q.size() != 2) begin fails++; $display("FAIL two_rx_count pass %0d: got %0d want 2", pass, rx_q.size()); end
            if (pass == 1) begin
                tests++;
                if (bus.tx_empty !== 1'b1) begin fails++; $display("FAIL two_underrun_empty: got %b want 1", bus.tx_empty); end
            end
        end
        last_rx = 8'h34;
    endtask

    task automatic test_abort();
        int e0;
        m_cpol = 0; m_cpha = 1; clear_plan();
        f_mo[0] = 8'hE7; model_frame(1);
        rx_q.delete(); e0 = ferr_cnt;
        run_frame(1, 3);
        tests++;
        if (ferr_cnt - e0 != 1) begin fails++; $display("FAIL abort_frame_err: got %0d pulses want 1", ferr_cnt - e0); end
        tests++;
        if (rx_q.size() != 0) begin fails++; $display("FAIL abort_no_rx_valid: got %0d want 0", rx_q.size()); end
        tests++;
        if (bus.rx_data !== last_rx) begin fails++; $display("FAIL abort_rx_kept: got %h want %h", bus.rx_data, last_rx); end
        clear_plan(); f_mo[0] = 8'hF0; model_frame(1);
        rx_q.delete(); e0 = ferr_cnt;
        run_frame(1, DATA_W);
        tests++;
        if (rx_q.size() != 1 || bus.rx_data !== 8'hF0 || ferr_cnt != e0) begin
            fails++; $display("FAIL abort_next_frame: got %0d words rx %h errs %0d want 1 f0 0", rx_q.size(), bus.rx_data, ferr_cnt - e0);
        end
        last_rx = 8'hF0;
    endtask

    task automatic test_reset_mid();
        int e0, r0;
        logic [13:0] obs;
        logic [DATA_W-1:0] d;
        m_cpol = 0; m_cpha = 0; clear_plan();
        host_write(DATA_W'($urandom));
        bus.cpol = 0; bus.cpha = 0; bus.sclk = 0;
        wait_clk(H);
        bus.ss = 1'b0;
        wait_clk(H);
        f_mo[0] = DATA_W'($urandom);
        r0 = rx_q.size(); e0 = ferr_cnt;
        xfer_word(0, 5);
        rst = 1'b0;
        wait_clk(2);
        rst = 1'b1;
        model_hold = '0;
        obs = {bus.busy, bus.miso, bus.miso_oe, bus.rx_valid, bus.frame_err, bus.tx_empty, bus.rx_data};
        tests++;
        if (obs !== 14'b00000_1_00000000) begin fails++; $display("FAIL rst_mid_outputs: got %b want %b", obs, 14'b00000_1_00000000); end
        wait_clk(H);
        bus.ss = 1'b1;
        wait_clk(H);
        tests++;
        if (bus.busy !== 1'b0 || rx_q.size() != r0 || ferr_cnt != e0) begin
            fails++; $display("FAIL rst_mid_no_pulses: busy %b rx %0d errs %0d want 0 0 0", bus.busy, rx_q.size() - r0, ferr_cnt - e0);
        end
        d = DATA_W'($urandom);
        host_write(d);
        f_mo[0] = 8'h55; model_frame(1);
        rx_q.delete();
        run_frame(1, DATA_W);
        tests++;
        if (rx_q.size() != 1 || bus.rx_data !== 8'h55) begin fails++; $display("FAIL rst_mid_next_rx: got %0d words rx %h want 1 55", rx_q.size(), bus.rx_data); end
        tests++;
        if (f_mi[0] !== d) begin fails++; $display("FAIL rst_mid_next_master: got %h want %h", f_mi[0], d); end
        last_rx = 8'h55;
    endtask

    task automatic test_coincident();
        logic [DATA_W-1:0] a;
        m_cpol = 0; m_cpha = 0; clear_plan();
        a = DATA_W'($urandom);
        host_write(a);
        f_mo[0] = DATA_W'($urandom); f_mo[1] = DATA_W'($urandom);
        f_end[0] = 1'b1; f_end_dat[0] = a ^ 8'hA5;
        model_frame(2);
        empty_after_we = 1'bx;
        rx_q.delete();
        run_frame(2, DATA_W);
        tests++;
        if (empty_after_we !== 1'b0) begin fails++; $display("FAIL coinc_tx_empty: got %b want 0", empty_after_we); end
        tests++;
        if (f_mi[0] !== a || f_mi[1] !== (a ^ 8'hA5)) begin
            fails++; $display("FAIL coinc_master: got %h %h want %h %h", f_mi[0], f_mi[1], a, a ^ 8'hA5);
        end
        tests++;
        if (rx_q.size() != 2 || bus.rx_data !== f_mo[1]) begin fails++; $display("FAIL coinc_rx: got %0d words rx %h want 2 %h", rx_q.size(), bus.rx_data, f_mo[1]); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int nw, e0;
            logic [DATA_W-1:0] got;
            m_cpol = 1'($urandom); m_cpha = 1'($urandom); scramble = 1'b1;
            nw = $urandom_range(1, 3);
            clear_plan();
            if ($urandom_range(0, 1) == 1) host_write(DATA_W'($urandom));
            for (int w = 0; w < nw; w++) begin
                f_mo[w]      = DATA_W'($urandom);
                f_mid[w]     = 1'($urandom);
                f_mid_dat[w] = DATA_W'($urandom);
                f_end[w]     = 1'($urandom);
                f_end_dat[w] = DATA_W'($urandom);
            end
            model_frame(nw);
            rx_q.delete(); e0 = ferr_cnt;
            run_frame(nw, DATA_W);
            for (int w = 0; w < nw; w++) begin
                got = (w < rx_q.size()) ? rx_q[w] : 'x;
                tests++;
                if (got !== f_mo[w]) begin fails++; $display("FAIL rand%0d_rx[%0d]: got %h want %h", f, w, got, f_mo[w]); end
                tests++;
                if (f_mi[w] !== f_exp[w]) begin fails++; $display("FAIL rand%0d_master[%0d]: got %h want %h", f, w, f_mi[w], f_exp[w]); end
            end
            tests++;
            if (miso_start !== (m_cpha ? 1'b0 : f_exp[0][DATA_W-1])) begin
                fails++; $display("FAIL rand%0d_miso_start: got %b want %b", f, miso_start, m_cpha ? 1'b0 : f_exp[0][DATA_W-1]);
            end
            tests++;
            if (rx_q.size() != nw || ferr_cnt != e0 || bus.tx_empty !== !f_end[nw-1]) begin
                fails++; $display("FAIL rand%0d_status: got words %0d errs %0d empty %b want %0d 0 %b",
                                  f, rx_q.size(), ferr_cnt - e0, bus.tx_empty, nw, !f_end[nw-1]);
            end
        end
        scramble = 1'b0;
    endtask

    initial begin
        bus.sclk = 0; bus.ss = 1; bus.mosi = 0; bus.cpol = 0; bus.cpha = 0;
        bus.tx_data = '0; bus.tx_we = 0;
        test_reset();
        test_mode0();
        test_mode3();
        test_two_word();
        test_abort();
        test_reset_mid();
        test_coincident();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave (target) for the other end of the team's `spi` master link.
- Samples `sclk`/`ss`/`mosi` in the system `clk` domain, drives `miso`, and delivers received words on a valid-pulse interface.
- Supports all four CPOL/CPHA modes and multi-word frames while `ss` is held low.
- Sits between the board-level SPI pins and the local register/loopback logic used for master-slave loopback testing.

Parameters:
DATA_W, 8, bits per word (MSB first)
SYNC_STAGES, 2, synchronizer depth on sclk/ss/mosi (legal values 2-3)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
sclk  input  1  SPI serial clock from master (asynchronous to clk)
ss  input  1  slave select, active-low
mosi  input  1  master-out serial data
cpol  input  1  clock idle level; captured at frame start
cpha  input  1  clock phase; captured at frame start
tx_data  input  DATA_W  next word to transmit
tx_we  input  1  one-cycle write strobe for tx_data into the TX holding register
miso  output  1  slave-out serial data
miso_oe  output  1  miso output enable (high while selected)
rx_data  output  DATA_W  last complete received word
rx_valid  output  1  one-cycle pulse when rx_data updates
busy  output  1  high while a frame is active
tx_empty  output  1  TX holding register consumed and not rewritten
frame_err  output  1  one-cycle pulse when ss deasserts mid-word

Behaviour:
- Reset (rst==0 at posedge clk):
  - All outputs go to 0, except tx_empty=1.
  - Holding register, shift registers, bit counter and synchronizers are cleared; state goes to IDLE.
  - Reset overrides everything, including an in-progress frame; no rx_valid or frame_err pulse is generated.
- Synchronization:
  - sclk, ss and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synced stage with its previous value.
  - Pin-to-detected-edge latency is SYNC_STAGES+1 clk.
  - Requirement on the master: sclk high and low times are each >= SYNC_STAGES+2 clk periods.
- Edge definitions:
  - leading = rising if cpol_q==0, falling if cpol_q==1; trailing is the opposite edge.
  - cpha_q==0: sample mosi on leading, shift miso on trailing.
  - cpha_q==1: shift miso on leading, sample mosi on trailing.
- State IDLE:
  - busy=0, miso_oe=0, miso=0.
  - On synced ss falling edge: capture cpol_q/cpha_q; load the TX shift register from the holding register; set tx_empty=1; clear bit_cnt; go to ACTIVE.
  - If cpha_q==0, miso presents the MSB in the same cycle.
- State ACTIVE:
  - busy=1, miso_oe=1.
  - Sample edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt++.
  - Shift edge: miso <= next TX bit (MSB first).
    - cpha_q==1: the first leading edge puts the MSB out.
    - cpha_q==0: the first trailing edge puts out bit DATA_W-2.
  - On the sample edge where bit_cnt reaches DATA_W:
    - rx_data <= completed word; rx_valid pulses 1 cycle (the cycle after that edge is detected).
    - bit_cnt <= 0; TX shift register reloads from the holding register; tx_empty=1.
    - cpha_q==0: the new MSB appears on the next trailing edge.
    - cpha_q==1: the new MSB appears on the next leading edge.
  - Synced ss rising edge: go to IDLE.
    - If bit_cnt != 0, pulse frame_err and discard the partial word.
    - No rx_valid is generated.
- TX holding register:
  - tx_we loads tx_data and clears tx_empty, in any state.
  - If tx_we coincides with a reload, the new tx_data is loaded into the shift register directly and tx_empty stays 0.
  - Underrun (reload with tx_empty==1) retransmits the stale holding value; no error flag.
- Simultaneous events:
  - ss rise in the same cycle as a sample edge: the sample is taken first, then the frame ends.
  - If that sample completes a word, rx_valid pulses and frame_err does not.
- cpol/cpha changes while busy are ignored until the next frame.
- Counter widths: bit_cnt is clog2(DATA_W)+1 bits. No wrap beyond DATA_W.

Test Plan:
- Mode 0 (cpol=0, cpha=0), tx_we with tx_data=8'h3C, master sends 8'hA5 (clk_div=10) -> rx_data=8'hA5; one rx_valid pulse; master rx_data=8'h3C; busy high from ss-fall+3 to ss-rise+3 clk.
- Mode 3 (cpol=1, cpha=1), slave tx 8'h81, master sends 8'h7E -> rx_data=8'h7E, master receives 8'h81; MSB on miso only after the first falling sclk.
- Two-word frame with ss held low:
  - Stimulus: master sends 8'h12 then 8'h34; slave writes 8'hC3, then 8'h5A during word 1.
  - Response: rx_valid pulses twice with 8'h12, 8'h34; master sees 8'hC3, 8'h5A.
  - Without the second tx_we: tx_empty=1 and 8'hC3 is repeated.
- Abort: ss deasserted after 3 sclk cycles of mode 1 -> frame_err one pulse, no rx_valid, rx_data unchanged; next full frame of 8'hF0 received correctly.
- rst=0 mid-frame (bit 5), held 2 clk, then released -> all outputs 0, tx_empty=1, no pulses; the following frame of 8'h55 received correctly after a fresh ss fall.
- tx_we coincident with reload at the end of word 1 -> the newly written value is transmitted in word 2; tx_empty=0 afterwards.
